// File: rtl/motor_pwm_guard.sv
// Two-channel motor PWM driver guarded by an overcurrent lockout.
//
// Turns duty/direction commands into gated PWM and direction pins for motors A and B.
// Effective duty soft-starts one step per PWM period. A direction change first ramps the
// duty down to zero, then flips the pin. An overcurrent flag latches a fault that needs
// a clear_fault press, with oc low, to enter a cooldown before the block may run again.
//
// Ports:
//   clock, reset        system clock; asynchronous active-high reset
//   enable              run request (level)
//   duty_a/b, dir_a/b   commanded duty (0..255 of 256) and direction per motor
//   oc                  overcurrent flag from the comparator (level, active-high)
//   clear_fault         fault-acknowledge button; its rising edge is detected here
//   pwm_a/b             gated PWM outputs
//   dir_a_out/b_out     applied direction per motor
//   fault               high in FAULT and COOLDOWN
//   state               IDLE=0, RUN=1, FAULT=2, COOLDOWN=3
//   fault_count         saturating count of FAULT entries
module motor_pwm_guard #(
  parameter int unsigned PRESCALE        = 20,
  parameter int unsigned COOLDOWN_CYCLES = 50000000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] duty_a,
  input  logic [7:0] duty_b,
  input  logic       dir_a,
  input  logic       dir_b,
  input  logic       oc,
  input  logic       clear_fault,
  output logic       pwm_a,
  output logic       pwm_b,
  output logic       dir_a_out,
  output logic       dir_b_out,
  output logic       fault,
  output logic [1:0] state,
  output logic [7:0] fault_count
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRun      = 2'd1,
    StFault    = 2'd2,
    StCooldown = 2'd3
  } state_e;

  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0]   PsMax   = PsW'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CoolMax = CNT_W'(COOLDOWN_CYCLES - 1);

  state_e           state_q, state_d;
  logic [PsW-1:0]   prescaler_q, prescaler_d;
  logic [7:0]       pwm_cnt_q, pwm_cnt_d;
  logic [CNT_W-1:0] cool_cnt_q, cool_cnt_d;
  logic [7:0]       fault_count_q, fault_count_d;
  logic [1:0][7:0]  duty_eff_q, duty_eff_d;
  logic [1:0]       dir_out_q, dir_out_d;
  logic [1:0]       pwm_q, pwm_d;
  logic             oc_q;
  logic             clear_fault_q;

  logic            tick;
  logic            boundary;
  logic            clr_rise;
  logic            enter_fault;
  logic [1:0][7:0] duty_cmd;
  logic [1:0]      dir_cmd;

  assign duty_cmd = {duty_b, duty_a};
  assign dir_cmd  = {dir_b, dir_a};
  assign clr_rise = clear_fault & ~clear_fault_q;

  // Free-running timebase; a period boundary is the tick on which pwm_cnt wraps to 0.
  always_comb begin
    tick        = (prescaler_q == PsMax);
    prescaler_d = tick ? '0 : prescaler_q + PsW'(1);
    pwm_cnt_d   = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    boundary    = tick && (pwm_cnt_q == 8'hFF);
  end

  // State machine, priority oc_q > clear > enable.
  always_comb begin
    state_d       = state_q;
    cool_cnt_d    = cool_cnt_q;
    fault_count_d = fault_count_q;
    enter_fault   = 1'b0;
    case (state_q)
      StIdle: begin
        if (oc_q)        enter_fault = 1'b1;
        else if (enable) state_d = StRun;
      end
      StRun: begin
        if (oc_q)         enter_fault = 1'b1;
        else if (!enable) state_d = StIdle;
      end
      StFault: begin
        // A press while oc is still high is simply lost; a fresh edge is required.
        if (!oc_q && clr_rise) begin
          state_d    = StCooldown;
          cool_cnt_d = '0;
        end
      end
      StCooldown: begin
        cool_cnt_d = cool_cnt_q + CNT_W'(1);
        if (oc_q)                         enter_fault = 1'b1;
        else if (cool_cnt_q == CoolMax)   state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (enter_fault) begin
      state_d = StFault;
      if (fault_count_q != 8'hFF) fault_count_d = fault_count_q + 8'd1;
    end
  end

  // Per-channel ramp. Duty is only non-zero while staying in RUN; any exit clears it.
  always_comb begin
    duty_eff_d = duty_eff_q;
    dir_out_d  = dir_out_q;
    pwm_d      = '0;
    for (int i = 0; i < 2; i++) begin
      if (state_q == StRun && state_d == StRun) begin
        if (boundary) begin
          if (dir_cmd[i] != dir_out_q[i]) begin
            // Reverse only once the motor has been ramped fully down.
            if (duty_eff_q[i] == 8'd0) dir_out_d[i]  = dir_cmd[i];
            else                       duty_eff_d[i] = duty_eff_q[i] - 8'd1;
          end else if (duty_eff_q[i] < duty_cmd[i]) begin
            duty_eff_d[i] = duty_eff_q[i] + 8'd1;
          end else if (duty_eff_q[i] > duty_cmd[i]) begin
            duty_eff_d[i] = duty_eff_q[i] - 8'd1;
          end
        end
      end else begin
        duty_eff_d[i] = 8'd0;
      end
      // Registered from next-state values so the pin lines up with pwm_cnt/duty_eff.
      pwm_d[i] = (state_d == StRun) && (pwm_cnt_d < duty_eff_d[i]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      prescaler_q   <= '0;
      pwm_cnt_q     <= '0;
      cool_cnt_q    <= '0;
      fault_count_q <= '0;
      duty_eff_q    <= '0;
      dir_out_q     <= '0;
      pwm_q         <= '0;
      oc_q          <= 1'b0;
      clear_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      prescaler_q   <= prescaler_d;
      pwm_cnt_q     <= pwm_cnt_d;
      cool_cnt_q    <= cool_cnt_d;
      fault_count_q <= fault_count_d;
      duty_eff_q    <= duty_eff_d;
      dir_out_q     <= dir_out_d;
      pwm_q         <= pwm_d;
      oc_q          <= oc;
      clear_fault_q <= clear_fault;
    end
  end

  assign pwm_a       = pwm_q[0];
  assign pwm_b       = pwm_q[1];
  assign dir_a_out   = dir_out_q[0];
  assign dir_b_out   = dir_out_q[1];
  assign state       = state_q;
  assign fault       = (state_q == StFault) || (state_q == StCooldown);
  assign fault_count = fault_count_q;

endmodule

// File: tb/tb_motor_pwm_guard.sv
module tb_motor_pwm_guard;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] duty_a = 8'd0;
  logic [7:0] duty_b = 8'd0;
  logic       dir_a = 1'b0;
  logic       dir_b = 1'b0;
  logic       oc = 1'b0;
  logic       clear_fault = 1'b0;
  logic       pwm_a, pwm_b, dir_a_out, dir_b_out, fault;
  logic [1:0] state;
  logic [7:0] fault_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;          // edges since reset release == pwm_cnt model (PRESCALE=1)
  logic last_dir = 1'b0;

  motor_pwm_guard #(
    .PRESCALE(1),
    .COOLDOWN_CYCLES(16),
    .CNT_W(5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .duty_a(duty_a),
    .duty_b(duty_b),
    .dir_a(dir_a),
    .dir_b(dir_b),
    .oc(oc),
    .clear_fault(clear_fault),
    .pwm_a(pwm_a),
    .pwm_b(pwm_b),
    .dir_a_out(dir_a_out),
    .dir_b_out(dir_b_out),
    .fault(fault),
    .state(state),
    .fault_count(fault_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  // Advance until the next edge is a period boundary (pwm_cnt 255 -> 0).
  task automatic align();
    while ((cyc % 256) != 255) step();
  endtask

  // One full PWM period; counts high samples and dir flips that coincide with pwm_a high.
  task automatic run_window(output int hi_a, output int hi_b, output logic dir0,
                            output int glitch);
    hi_a = 0;
    hi_b = 0;
    glitch = 0;
    dir0 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (i == 0) dir0 = dir_a_out;
      if (dir_a_out !== last_dir && pwm_a === 1'b1) glitch++;
      last_dir = dir_a_out;
      if (pwm_a === 1'b1) hi_a++;
      if (pwm_b === 1'b1) hi_b++;
    end
  endtask

  initial begin
    int   hi_a, hi_b, glitch;
    logic dir0;
    int   exp_soft[5] = '{1, 2, 3, 4, 4};
    int   exp_rev[9]  = '{3, 2, 1, 0, 0, 1, 2, 3, 4};
    logic exp_dir[9]  = '{0, 0, 0, 0, 1, 1, 1, 1, 1};

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_pwm_a", pwm_a, 0);
    chk("rst_pwm_b", pwm_b, 0);
    chk("rst_dir_a", dir_a_out, 0);
    chk("rst_fault", fault, 0);
    chk("rst_state", state, 0);
    chk("rst_fcount", fault_count, 0);
    reset = 1'b0;
    cyc = 0;

    // Soft start
    enable = 1'b1;
    duty_a = 8'd4;
    dir_a  = 1'b0;
    step();
    chk("run_state", state, 1);
    align();
    for (int w = 0; w < 5; w++) begin
      run_window(hi_a, hi_b, dir0, glitch);
      chk($sformatf("soft_win%0d_a", w), hi_a, exp_soft[w]);
      chk($sformatf("soft_win%0d_b", w), hi_b, 0);
    end

    // Direction reversal: set just before the next boundary
    dir_a = 1'b1;
    for (int w = 0; w < 9; w++) begin
      run_window(hi_a, hi_b, dir0, glitch);
      chk($sformatf("rev_win%0d_a", w), hi_a, exp_rev[w]);
      chk($sformatf("rev_win%0d_dir", w), dir0, exp_dir[w]);
      chk($sformatf("rev_win%0d_glitch", w), glitch, 0);
    end

    // Overcurrent trip while pwm_a is high
    step();
    chk("pre_trip_pwm", pwm_a, 1);
    oc = 1'b1;
    step();
    oc = 1'b0;
    step();
    chk("trip_pwm_a", pwm_a, 0);
    chk("trip_pwm_b", pwm_b, 0);
    chk("trip_state", state, 2);
    chk("trip_fault", fault, 1);
    chk("trip_fcount", fault_count, 1);
    chk("trip_dir_hold", dir_a_out, 1);

    // Clear ignored while oc is still high
    oc = 1'b1;
    step();
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    step();
    chk("clr_ignored", state, 2);

    // Valid clear -> cooldown; oc again on cooldown cycle 5
    oc = 1'b0;
    step();
    step();
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    chk("cool_state", state, 3);
    chk("cool_fault", fault, 1);
    repeat (4) step();
    oc = 1'b1;
    step();
    step();
    chk("cool_trip_state", state, 2);
    chk("cool_trip_fcount", fault_count, 2);
    chk("cool_trip_pwm", pwm_a, 0);

    // Full cooldown -> IDLE -> RUN
    oc = 1'b0;
    step();
    step();
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    repeat (15) step();
    chk("cool_last_state", state, 3);
    chk("cool_pwm", pwm_a, 0);
    step();
    chk("cool_exit_idle", state, 0);
    chk("idle_fault", fault, 0);
    step();
    chk("restart_run", state, 1);
    align();
    run_window(hi_a, hi_b, dir0, glitch);
    chk("restart_win0", hi_a, 1);
    run_window(hi_a, hi_b, dir0, glitch);
    chk("restart_win1", hi_a, 2);

    // Enable drop while pwm_a is high
    step();
    chk("drop_pre_pwm", pwm_a, 1);
    enable = 1'b0;
    step();
    step();
    chk("drop_pwm", pwm_a, 0);
    chk("drop_state", state, 0);
    enable = 1'b1;
    step();
    chk("reen_state", state, 1);
    align();
    run_window(hi_a, hi_b, dir0, glitch);
    chk("reen_win0", hi_a, 1);

    // Saturation: 258 more fault entries (260 total)
    oc = 1'b1;
    step();
    step();
    chk("sat_first", fault_count, 3);
    for (int k = 0; k < 257; k++) begin
      oc = 1'b0;
      step();
      step();
      clear_fault = 1'b1;
      step();
      clear_fault = 1'b0;
      oc = 1'b1;
      step();
      step();
    end
    chk("sat_state", state, 2);
    chk("sat_fcount", fault_count, 255);

    // Back to RUN with pwm high, then asynchronous reset mid-period
    oc = 1'b0;
    step();
    step();
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    repeat (17) step();
    chk("pre_rst_state", state, 1);
    align();
    step();
    chk("pre_rst_pwm", pwm_a, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_pwm_a", pwm_a, 0);
    chk("arst_dir_a", dir_a_out, 0);
    chk("arst_state", state, 0);
    chk("arst_fault", fault, 0);
    chk("arst_fcount", fault_count, 0);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
